// File: rtl/conv_x_tx.sv
// -----------------------------------------------------------------------------
// conv_x_tx
// Transmit-side source for the x input stream of a conv_* convolution block.
// A frame of SIZE_X signed samples is loaded from a host-side stream into a
// single-port RAM. On start, the frame is replayed over a valid/ready
// interface at one sample per cycle while x_ready stays high.
//
// Parameters:
//   T       sample width in bits
//   SIZE_X  samples per frame (must be at least 2)
//
// Ports:
//   clk       clock, all logic on the rising edge
//   reset     asynchronous active-low reset
//   ld_data   frame sample being loaded (signed)
//   ld_valid  ld_data valid
//   ld_ready  buffer accepts a load sample
//   start     single-cycle request to transmit the buffered frame
//   clear     (CONV_X_TX_REPLAY_EN only) drop the retained frame, IDLE only
//   busy      high from accepted start until after the last x handshake
//   done      one-cycle pulse after the last x handshake
//   x_data    sample to the conv block (signed)
//   x_valid   x_data valid
//   x_ready   conv block accepts x_data
//
// Optional feature macro: CONV_X_TX_REPLAY_EN
//   Undefined: the frame is released after every transmission.
//   Defined:   the frame is retained so every start resends it; the clear
//              input releases it (only honoured in IDLE).
// -----------------------------------------------------------------------------
module conv_x_tx #(
    parameter int T      = 16,
    parameter int SIZE_X = 96
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] ld_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic                start,
`ifdef CONV_X_TX_REPLAY_EN
    input  logic                clear,
`endif
    output logic                busy,
    output logic                done,
    output logic signed [T-1:0] x_data,
    output logic                x_valid,
    input  logic                x_ready
);

    // Counter width leaves one spare bit so SIZE_X itself is representable.
    localparam int AW = $clog2(SIZE_X) + 32'd1;
    localparam int MW = $clog2(SIZE_X);

    localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] CNT_ONE  = AW'(32'd1);
    localparam logic [AW-1:0] CNT_LAST = AW'(SIZE_X - 32'd1);
    localparam logic [AW-1:0] CNT_SIZE = AW'(SIZE_X);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        SEND     = 2'd2,
        FIN      = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                frame_full_r;
    logic                frame_full_nxt_s;
    logic [AW-1:0]       ld_cnt_r;
    logic [AW-1:0]       ld_cnt_nxt_s;
    logic [AW-1:0]       rd_cnt_r;
    logic [AW-1:0]       rd_cnt_nxt_s;
    logic [AW-1:0]       tx_cnt_r;
    logic [AW-1:0]       tx_cnt_nxt_s;
    logic signed [T-1:0] x_data_nxt_s;
    logic                x_valid_nxt_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;

    // Single-port RAM; ram_q_r is its registered read port and doubles as the
    // one-entry prefetch register holding the sample after x_data.
    logic signed [T-1:0] mem_r [SIZE_X];
    logic signed [T-1:0] ram_q_r;
    logic                ram_we_s;
    logic                ram_re_s;
    logic [MW-1:0]       ram_addr_s;

    // Next-state, counter, RAM-port and output-register decode.
    always_comb begin
        state_nxt_s      = state_r;
        frame_full_nxt_s = frame_full_r;
        ld_cnt_nxt_s     = ld_cnt_r;
        rd_cnt_nxt_s     = rd_cnt_r;
        tx_cnt_nxt_s     = tx_cnt_r;
        x_data_nxt_s     = x_data;
        x_valid_nxt_s    = x_valid;
        busy_nxt_s       = busy;
        done_nxt_s       = 1'b0;
        ram_we_s         = 1'b0;
        ram_re_s         = 1'b0;
        ram_addr_s       = rd_cnt_r[MW-1:0];

        case (state_r)
            IDLE: begin
                if (start && frame_full_r) begin
                    // Read of sample 0 goes out in the start cycle itself so
                    // x_valid can rise two cycles later.
                    state_nxt_s  = PREFETCH;
                    busy_nxt_s   = 1'b1;
                    ram_re_s     = 1'b1;
                    ram_addr_s   = {MW{1'b0}};
                    rd_cnt_nxt_s = CNT_ONE;
                    tx_cnt_nxt_s = CNT_ZERO;
                end else if (ld_valid && ld_ready) begin
                    ram_we_s   = 1'b1;
                    ram_addr_s = ld_cnt_r[MW-1:0];
                    if (ld_cnt_r == CNT_LAST) begin
                        ld_cnt_nxt_s     = CNT_ZERO;
                        frame_full_nxt_s = 1'b1;
                    end else begin
                        ld_cnt_nxt_s = ld_cnt_r + CNT_ONE;
                    end
`ifdef CONV_X_TX_REPLAY_EN
                end else if (clear) begin
                    frame_full_nxt_s = 1'b0;
`endif
                end else begin
                    ram_we_s = 1'b0;
                end
            end

            PREFETCH: begin
                // ram_q_r holds sample 0 now; move it out and fetch sample 1.
                ram_re_s      = 1'b1;
                ram_addr_s    = rd_cnt_r[MW-1:0];
                rd_cnt_nxt_s  = rd_cnt_r + CNT_ONE;
                x_data_nxt_s  = ram_q_r;
                x_valid_nxt_s = 1'b1;
                state_nxt_s   = SEND;
            end

            SEND: begin
                if (x_valid && x_ready) begin
                    tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                    if (tx_cnt_r == CNT_LAST) begin
                        x_valid_nxt_s = 1'b0;
                        busy_nxt_s    = 1'b0;
                        done_nxt_s    = 1'b1;
                        tx_cnt_nxt_s  = CNT_ZERO;
                        state_nxt_s   = FIN;
                    end else begin
                        x_data_nxt_s = ram_q_r;
                        if (rd_cnt_r < CNT_SIZE) begin
                            ram_re_s     = 1'b1;
                            ram_addr_s   = rd_cnt_r[MW-1:0];
                            rd_cnt_nxt_s = rd_cnt_r + CNT_ONE;
                        end else begin
                            ram_re_s = 1'b0;
                        end
                    end
                end else begin
                    // Stall: output and prefetch registers hold, no read.
                    x_valid_nxt_s = x_valid;
                end
            end

            FIN: begin
                state_nxt_s = IDLE;
`ifdef CONV_X_TX_REPLAY_EN
                frame_full_nxt_s = frame_full_r;
`else
                frame_full_nxt_s = 1'b0;
`endif
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            frame_full_r <= 1'b0;
            ld_cnt_r     <= CNT_ZERO;
            rd_cnt_r     <= CNT_ZERO;
            tx_cnt_r     <= CNT_ZERO;
            x_data       <= {T{1'b0}};
            x_valid      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ld_ready     <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            frame_full_r <= frame_full_nxt_s;
            ld_cnt_r     <= ld_cnt_nxt_s;
            rd_cnt_r     <= rd_cnt_nxt_s;
            tx_cnt_r     <= tx_cnt_nxt_s;
            x_data       <= x_data_nxt_s;
            x_valid      <= x_valid_nxt_s;
            busy         <= busy_nxt_s;
            done         <= done_nxt_s;
            // Registered form of (state==IDLE && !frame_full).
            ld_ready     <= (state_nxt_s == IDLE) && !frame_full_nxt_s;
        end
    end

    // RAM array write port (no reset on storage).
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_addr_s] <= ld_data;
        end
    end

    // RAM registered read port; holds its value when no read is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_q_r <= {T{1'b0}};
        end else if (ram_re_s) begin
            ram_q_r <= mem_r[ram_addr_s];
        end
    end

endmodule

// File: tb/tb_conv_x_tx.sv
module tb_conv_x_tx;

    localparam int T      = 16;
    localparam int SIZE_X = 96;
`ifdef CONV_X_TX_REPLAY_EN
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic signed [T-1:0] ld_data;
    logic                ld_valid;
    logic                ld_ready;
    logic                start;
    logic                busy;
    logic                done;
    logic signed [T-1:0] x_data;
    logic                x_valid;
    logic                x_ready;
`ifdef CONV_X_TX_REPLAY_EN
    logic                clear;
    int                  clear_at;
`endif

    int n_checks;
    int n_fail;

    // Reference model: the frame as accepted on the load port, in order.
    logic signed [T-1:0] frame_m[$];

    typedef struct {
        int base;       // first sample value (successive samples count up)
        bit rnd;        // random sample values instead of base+i
        int gap;        // ld_valid period: 1 every cycle, 3 one of three, 0 random
        int rdy_mode;   // 0 x_ready high, 1 pattern 1,0,0,1, 2 random
        int exp_first;  // cycles from start cycle to first x_valid
        int exp_done;   // cycle index of done (start cycle = 0), -1 if not fixed
    } vec_t;

    vec_t vecs[6];

    conv_x_tx #(.T(T), .SIZE_X(SIZE_X)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .start    (start),
`ifdef CONV_X_TX_REPLAY_EN
        .clear    (clear),
`endif
        .busy     (busy),
        .done     (done),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Watch n cycles and expect no transmit activity at all.
    task automatic watch_idle(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (x_valid || busy || done) bad++;
            step();
            start = 1'b0;
        end
        chk(name, bad, 0);
    endtask

    // Load one frame; optionally assert start on the final accepted write.
    task automatic load_frame(input int base, input bit rnd, input int gap, input bit start_last);
        int acc;
        int cyc;
        int early_drop;
        bit vld;
        logic signed [T-1:0] v;
        acc = 0;
        cyc = 0;
        early_drop = 0;
        frame_m.delete();
        while (acc < SIZE_X && cyc < 3000) begin
            if (gap == 0) vld = 1'($urandom_range(0, 1));
            else          vld = ((cyc % gap) == 0);
            if (rnd) v = T'($urandom);
            else     v = T'(base + acc);
            ld_valid = vld;
            ld_data  = v;
            start    = start_last && vld && (acc == SIZE_X - 1);
            if (!ld_ready) early_drop++;
            if (vld && ld_ready) begin
                frame_m.push_back(v);
                acc++;
            end
            step();
            cyc++;
        end
        ld_valid = 1'b0;
        start    = 1'b0;
        chk("load_accepted_count", acc, SIZE_X);
        chk("ld_ready_low_during_load", early_drop, 0);
        // Now in the cycle right after the final write.
        chk("ld_ready_after_full", ld_ready, 0);
    endtask

    // Start a transmission and check it against the model frame.
    task automatic transmit(input int rdy_mode, input int exp_first, input int exp_done);
        logic signed [T-1:0] exp_q[$];
        logic signed [T-1:0] prev_d;
        logic signed [T-1:0] want;
        int k, first_k, hs, dones, done_k, unstable, busy_bad, late_valid;
        bit prev_stall;
        bit rdy;
        exp_q = frame_m;
        k = 0; first_k = -1; hs = 0; dones = 0; done_k = -1;
        unstable = 0; busy_bad = 0; late_valid = 0;
        prev_stall = 1'b0;
        prev_d = '0;
        while (k < 2000 && (done_k < 0 || k <= done_k + 3)) begin
            start = (k == 0);
`ifdef CONV_X_TX_REPLAY_EN
            clear = (k == clear_at);
`endif
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            x_ready = rdy;
            if (x_valid && first_k < 0) first_k = k;
            if (prev_stall && (!x_valid || x_data !== prev_d)) unstable++;
            if (hs >= SIZE_X && x_valid) late_valid++;
            if (k >= 1 && done_k < 0 && !done && !busy) busy_bad++;
            if (done) begin
                dones++;
                if (done_k < 0) done_k = k;
                if (busy) busy_bad++;
            end else if (done_k >= 0 && busy) begin
                busy_bad++;
            end
            if (done_k >= 0 && k == done_k + 1)
                chk("ld_ready_after_fin", ld_ready, REPLAY ? 0 : 1);
            if (x_valid && rdy) begin
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    chk("x_data_order", x_data, want);
                end
                hs++;
            end
            prev_stall = x_valid && !rdy;
            prev_d     = x_data;
            step();
            k++;
        end
        start   = 1'b0;
        x_ready = 1'b0;
`ifdef CONV_X_TX_REPLAY_EN
        clear   = 1'b0;
`endif
        chk("first_x_valid_cycle", first_k, exp_first);
        chk("handshake_count", hs, SIZE_X);
        chk("done_pulse_count", dones, 1);
        if (exp_done >= 0) chk("start_to_done_cycle", done_k, exp_done);
        chk("stall_stability_errors", unstable, 0);
        chk("busy_errors", busy_bad, 0);
        chk("x_valid_after_last", late_valid, 0);
    endtask

    // Release a retained frame so the next load can proceed.
    task automatic release_frame();
`ifdef CONV_X_TX_REPLAY_EN
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ld_ready_after_clear", ld_ready, 1);
`endif
    endtask

    initial begin
        int hs;
        int k;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ld_data  = '0;
        ld_valid = 1'b0;
        start    = 1'b0;
        x_ready  = 1'b0;
`ifdef CONV_X_TX_REPLAY_EN
        clear    = 1'b0;
        clear_at = -1;
`endif
        // Stimulus table: {inputs, expected timing}; sample values from model.
        vecs[0] = '{base: 0,     rnd: 1'b0, gap: 1, rdy_mode: 0, exp_first: 2, exp_done: SIZE_X + 2};
        vecs[1] = '{base: 0,     rnd: 1'b0, gap: 1, rdy_mode: 1, exp_first: 2, exp_done: -1};
        vecs[2] = '{base: 500,   rnd: 1'b0, gap: 3, rdy_mode: 0, exp_first: 2, exp_done: SIZE_X + 2};
        vecs[3] = '{base: 32700, rnd: 1'b0, gap: 1, rdy_mode: 2, exp_first: 2, exp_done: -1};
        vecs[4] = '{base: 0,     rnd: 1'b1, gap: 0, rdy_mode: 2, exp_first: 2, exp_done: -1};
        vecs[5] = '{base: 0,     rnd: 1'b1, gap: 1, rdy_mode: 0, exp_first: 2, exp_done: SIZE_X + 2};

        repeat (3) step();
        chk("reset_x_valid", x_valid, 0);
        chk("reset_x_data", x_data, 0);
        chk("reset_ld_ready", ld_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b1;
        step();

        // start with no frame buffered is ignored
        start = 1'b1;
        watch_idle("start_empty_ignored", 8);
        chk("ld_ready_after_empty_start", ld_ready, 1);

        for (int i = 0; i < 6; i++) begin
            load_frame(vecs[i].base, vecs[i].rnd, vecs[i].gap, 1'b0);
            transmit(vecs[i].rdy_mode, vecs[i].exp_first, vecs[i].exp_done);
            release_frame();
        end

        // start on the same cycle as the final load write is ignored
        load_frame(1000, 1'b0, 1, 1'b1);
        watch_idle("start_on_last_write_ignored", 8);
        chk("frame_kept_after_ignored_start", ld_ready, 0);
        transmit(0, 2, SIZE_X + 2);
        release_frame();

        // asynchronous reset after the 40th handshake
        load_frame(-5, 1'b0, 1, 1'b0);
        hs = 0;
        k  = 0;
        x_ready = 1'b1;
        start   = 1'b1;
        while (hs < 40 && k < 300) begin
            if (x_valid && x_ready) hs++;
            step();
            start = 1'b0;
            k++;
        end
        chk("busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_x_valid", x_valid, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ld_ready", ld_ready, 1);
        x_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_reset_ld_ready", ld_ready, 1);
        chk("post_reset_done", done, 0);
        load_frame(-5, 1'b0, 1, 1'b0);
        transmit(0, 2, SIZE_X + 2);
        release_frame();

`ifdef CONV_X_TX_REPLAY_EN
        // Retained frame is resent; clear while busy has no effect.
        load_frame(-300, 1'b0, 1, 1'b0);
        transmit(0, 2, SIZE_X + 2);
        clear_at = 10;
        transmit(1, 2, -1);
        clear_at = -1;
        step();
        chk("replay_ld_ready_held", ld_ready, 0);
        release_frame();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got still running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
